seg_scan_ctrl: RTL and testbench

Time-multiplexed 7-segment display scan controller. It sequences a digit-select counter across up to 4 common-anode digits and inserts a programmable blanking interval between digits to suppress ghosting. New display data arrives through a load/ack handshake and is applied only at frame boundaries, so a frame never shows a mix of old and new data. It sits between the lab's data/register logic and the board display pins.

---
 rtl/seg_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scan controller for up to 4
// common-anode digits. It inserts a blanking interval at the start of each
// digit slot. New data is applied only at frame boundaries (or immediately
// while idle), and each application is acknowledged with a single pulse.
//
// Ports:
//   clk, rst_n    - clock (posedge) and asynchronous active-low reset
//   en            - scan enable; low forces IDLE with the display dark
//   num_digits    - active digit count minus 1, latched at frame starts
//   digits_in     - four hex nibbles, digit k = digits_in[4k+3:4k]
//   dp_in         - decimal points, bit k = digit k, 1 = lit
//   load          - single-cycle request to capture digits_in/dp_in
//   load_ack      - one-cycle pulse when captured data becomes displayed
//   an, seg, dp   - active-low anodes, segments {g..a} and decimal point
//   digit_idx     - digit currently being scanned
//   frame_start   - one-cycle pulse on entry to the digit 0 slot
module seg_scan_ctrl #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned BLANK    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  num_digits,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic        load_ack,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_idx,
    output logic        frame_start
);

    localparam int unsigned   CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    ndig;
    logic [15:0]   sh_dig, st_dig;
    logic [3:0]    sh_dp, st_dp;
    logic          pending;

    logic          slot_end, boundary, nxt_show;
    logic [1:0]    nxt_idx;
    logic [CW-1:0] nxt_cnt;
    logic [15:0]   nxt_dig;
    logic [3:0]    nxt_dp;

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;  default: decode = 7'h0E;
        endcase
    endfunction

    // Next slot position and the shadow contents that will be visible after
    // this edge; registered outputs are decoded from these so that an/seg/dp
    // always match the state they are registered with.
    always_comb begin
        slot_end = (state != S_IDLE) && en && (cnt == CNT_LAST);
        boundary = slot_end && (digit_idx == ndig);

        nxt_dig = sh_dig;
        nxt_dp  = sh_dp;
        if (load && (state == S_IDLE || boundary)) begin
            // Idle or boundary-cycle loads bypass staging.
            nxt_dig = digits_in;
            nxt_dp  = dp_in;
        end else if (boundary && pending) begin
            nxt_dig = st_dig;
            nxt_dp  = st_dp;
        end

        if (state == S_IDLE || slot_end) begin
            nxt_idx  = (state == S_IDLE || boundary) ? 2'd0 : digit_idx + 2'd1;
            nxt_cnt  = '0;
            nxt_show = (BLANK == 0);
        end else begin
            nxt_idx  = digit_idx;
            nxt_cnt  = cnt + 1'b1;
            nxt_show = (32'(cnt) + 32'd1) >= BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            digit_idx   <= '0;
            ndig        <= '0;
            sh_dig      <= '0;
            sh_dp       <= '0;
            st_dig      <= '0;
            st_dp       <= '0;
            pending     <= 1'b0;
            an          <= '1;
            seg         <= '1;
            dp          <= 1'b1;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
            sh_dig      <= nxt_dig;
            sh_dp       <= nxt_dp;

            // A load that supersedes pending staging still yields one ack.
            if (load) begin
                if (state == S_IDLE || boundary) begin
                    load_ack <= 1'b1;
                    pending  <= 1'b0;
                end else begin
                    st_dig  <= digits_in;
                    st_dp   <= dp_in;
                    pending <= 1'b1;
                end
            end else if (boundary && pending) begin
                load_ack <= 1'b1;
                pending  <= 1'b0;
            end

            if (!en) begin
                state     <= S_IDLE;
                cnt       <= '0;
                digit_idx <= '0;
                an        <= '1;
                seg       <= '1;
                dp        <= 1'b1;
            end else begin
                state     <= nxt_show ? S_SHOW : S_BLANK;
                cnt       <= nxt_cnt;
                digit_idx <= nxt_idx;
                if (state == S_IDLE || boundary) begin
                    frame_start <= 1'b1;
                    ndig        <= num_digits;
                end
                an  <= nxt_show ? ~(4'b0001 << nxt_idx) : 4'hF;
                seg <= decode(nxt_dig[{nxt_idx, 2'b00} +: 4]);
                dp  <= ~nxt_dp[nxt_idx];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, en, load;
    logic [1:0]  num_digits;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;

    logic        load_ack, dp, frame_start;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  digit_idx;

    logic        nb_load_ack, nb_dp, nb_frame_start;
    logic [3:0]  nb_an;
    logic [6:0]  nb_seg;
    logic [1:0]  nb_digit_idx;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.PRESCALE(8), .BLANK(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .num_digits(num_digits),
        .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .load_ack(load_ack), .an(an), .seg(seg), .dp(dp),
        .digit_idx(digit_idx), .frame_start(frame_start)
    );

    seg_scan_ctrl #(.PRESCALE(8), .BLANK(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .en(en), .num_digits(num_digits),
        .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .load_ack(nb_load_ack), .an(nb_an), .seg(nb_seg), .dp(nb_dp),
        .digit_idx(nb_digit_idx), .frame_start(nb_frame_start)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; load = 1'b0; num_digits = 2'd0;
        digits_in = '0; dp_in = '0;
        tick;
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got=%h exp=F", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7F", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp); end
        checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", digit_idx); end
        checks++; if (load_ack !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("FAIL reset_pulses got ack=%b fs=%b exp 0/0", load_ack, frame_start); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_idle_load;
        digits_in = 16'h1234; dp_in = 4'b0001; load = 1'b1;
        tick;
        load = 1'b0;
        checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL idle_ack got=%b exp=1", load_ack); end
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL idle_an got=%h exp=F", an); end
        tick;
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL idle_ack_width got=%b exp=0", load_ack); end
    endtask

    task automatic test_scan;
        logic [6:0] segs [4];
        logic [1:0] s;
        int pos;
        logic [3:0] ea;
        segs[0] = 7'h19; segs[1] = 7'h30; segs[2] = 7'h24; segs[3] = 7'h79;
        num_digits = 2'd3; en = 1'b1;
        for (int k = 0; k < 64; k++) begin
            tick;
            s = 2'((k % 32) / 8); pos = k % 8;
            ea = (pos < 2) ? 4'hF : ~(4'b0001 << s);
            checks++; if (an !== ea) begin errors++; $display("FAIL scan_an k=%0d got=%h exp=%h", k, an, ea); end
            checks++; if (seg !== segs[s]) begin errors++; $display("FAIL scan_seg k=%0d got=%h exp=%h", k, seg, segs[s]); end
            checks++; if (dp !== (s != 2'd0)) begin errors++; $display("FAIL scan_dp k=%0d got=%b exp=%b", k, dp, (s != 2'd0)); end
            checks++; if (digit_idx !== s) begin errors++; $display("FAIL scan_idx k=%0d got=%0d exp=%0d", k, digit_idx, s); end
            checks++; if (frame_start !== (k % 32 == 0)) begin errors++; $display("FAIL scan_fs k=%0d got=%b exp=%b", k, frame_start, (k % 32 == 0)); end
        end
    endtask

    task automatic test_num_digits;
        logic [6:0] segs [4];
        logic [1:0] s;
        int pos;
        logic [3:0] ea;
        logic efs;
        segs[0] = 7'h19; segs[1] = 7'h30; segs[2] = 7'h24; segs[3] = 7'h79;
        for (int k = 0; k < 64; k++) begin
            if (k == 10) num_digits = 2'd1;
            tick;
            s   = (k < 32) ? 2'(k / 8) : 2'(((k - 32) % 16) / 8);
            pos = k % 8;
            efs = (k == 0) || (k >= 32 && (k - 32) % 16 == 0);
            ea  = (pos < 2) ? 4'hF : ~(4'b0001 << s);
            checks++; if (an !== ea) begin errors++; $display("FAIL ndig_an k=%0d got=%h exp=%h", k, an, ea); end
            checks++; if (seg !== segs[s]) begin errors++; $display("FAIL ndig_seg k=%0d got=%h exp=%h", k, seg, segs[s]); end
            checks++; if (frame_start !== efs) begin errors++; $display("FAIL ndig_fs k=%0d got=%b exp=%b", k, frame_start, efs); end
        end
    endtask

    task automatic test_latest_wins;
        logic [6:0] old_segs [4];
        logic [6:0] new_segs [4];
        logic [1:0] s;
        logic [6:0] es;
        logic ed;
        old_segs[0] = 7'h19; old_segs[1] = 7'h30; old_segs[2] = 7'h24; old_segs[3] = 7'h79;
        new_segs[0] = 7'h79; new_segs[1] = 7'h40; new_segs[2] = 7'h0E; new_segs[3] = 7'h06;
        num_digits = 2'd3;
        dp_in = 4'b1000;
        for (int k = 0; k < 64; k++) begin
            load = (k == 5) || (k == 12);
            digits_in = (k == 5) ? 16'hABCD : 16'hEF01;
            tick;
            s  = 2'((k % 32) / 8);
            es = (k < 32) ? old_segs[s] : new_segs[s];
            ed = (k < 32) ? (s != 2'd0) : (s != 2'd3);
            checks++; if (seg !== es) begin errors++; $display("FAIL latest_seg k=%0d got=%h exp=%h", k, seg, es); end
            checks++; if (dp !== ed) begin errors++; $display("FAIL latest_dp k=%0d got=%b exp=%b", k, dp, ed); end
            checks++; if (load_ack !== (k == 32)) begin errors++; $display("FAIL latest_ack k=%0d got=%b exp=%b", k, load_ack, (k == 32)); end
        end
        load = 1'b0;
    endtask

    task automatic test_boundary_load;
        logic [6:0] segs [4];
        logic [1:0] s;
        segs[0] = 7'h00; segs[1] = 7'h78; segs[2] = 7'h02; segs[3] = 7'h12;
        for (int k = 0; k < 32; k++) begin
            load = (k == 0);
            digits_in = 16'h5678; dp_in = 4'b0000;
            tick;
            s = 2'(k / 8);
            checks++; if (seg !== segs[s]) begin errors++; $display("FAIL bnd_seg k=%0d got=%h exp=%h", k, seg, segs[s]); end
            checks++; if (dp !== 1'b1) begin errors++; $display("FAIL bnd_dp k=%0d got=%b exp=1", k, dp); end
            checks++; if (load_ack !== (k == 0)) begin errors++; $display("FAIL bnd_ack k=%0d got=%b exp=%b", k, load_ack, (k == 0)); end
        end
        load = 1'b0;
    endtask

    task automatic test_en_drop;
        for (int k = 0; k < 21; k++) tick;
        checks++; if (an !== 4'hB || digit_idx !== 2'd2) begin errors++; $display("FAIL endrop_pre got an=%h idx=%0d exp B/2", an, digit_idx); end
        en = 1'b0;
        tick;
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL endrop_an got=%h exp=F", an); end
        checks++; if (seg !== 7'h7F || dp !== 1'b1) begin errors++; $display("FAIL endrop_seg got seg=%h dp=%b exp 7F/1", seg, dp); end
        checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL endrop_idx got=%0d exp=0", digit_idx); end
        tick;
        checks++; if (an !== 4'hF || frame_start !== 1'b0) begin errors++; $display("FAIL endrop_idle got an=%h fs=%b exp F/0", an, frame_start); end
        en = 1'b1;
        tick;
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL restart_fs got=%b exp=1", frame_start); end
        checks++; if (digit_idx !== 2'd0 || an !== 4'hF) begin errors++; $display("FAIL restart_pos got idx=%0d an=%h exp 0/F", digit_idx, an); end
        checks++; if (seg !== 7'h00) begin errors++; $display("FAIL restart_seg got=%h exp=00", seg); end
        tick; tick;
        checks++; if (an !== 4'hE) begin errors++; $display("FAIL restart_show got=%h exp=E", an); end
    endtask

    task automatic test_reset_mid_show;
        for (int k = 3; k <= 20; k++) tick;
        checks++; if (an !== 4'hB || digit_idx !== 2'd2) begin errors++; $display("FAIL midrst_pre got an=%h idx=%0d exp B/2", an, digit_idx); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin errors++; $display("FAIL midrst_out got an=%h seg=%h dp=%b exp F/7F/1", an, seg, dp); end
        checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL midrst_idx got=%0d exp=0", digit_idx); end
        #1 rst_n = 1'b1;
        tick;
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL midrst_fs got=%b exp=1", frame_start); end
        checks++; if (an !== 4'hF || seg !== 7'h40 || dp !== 1'b1) begin errors++; $display("FAIL midrst_first got an=%h seg=%h dp=%b exp F/40/1", an, seg, dp); end
        checks++; if (nb_frame_start !== 1'b1 || nb_an !== 4'hE) begin errors++; $display("FAIL nb_first got fs=%b an=%h exp 1/E", nb_frame_start, nb_an); end
    endtask

    task automatic test_blank0;
        logic [1:0] s;
        logic [3:0] ea;
        for (int k = 1; k < 40; k++) begin
            tick;
            s  = 2'((k % 32) / 8);
            ea = ~(4'b0001 << s);
            checks++; if (nb_an !== ea) begin errors++; $display("FAIL nb_an k=%0d got=%h exp=%h", k, nb_an, ea); end
            checks++; if (nb_frame_start !== (k % 32 == 0)) begin errors++; $display("FAIL nb_fs k=%0d got=%b exp=%b", k, nb_frame_start, (k % 32 == 0)); end
            checks++; if (nb_seg !== 7'h40) begin errors++; $display("FAIL nb_seg k=%0d got=%h exp=40", k, nb_seg); end
        end
    endtask

    initial begin
        test_reset;
        test_idle_load;
        test_scan;
        test_num_digits;
        test_latest_wins;
        test_boundary_load;
        test_en_drop;
        test_reset_mid_show;
        test_blank0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
